// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS execution-stage feeder blocks.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int OREG_W  = 20;
  localparam int ENTRY_W = INSTR_W + OREG_W;

  typedef enum logic {S_IDLE, S_WAIT} issue_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [OREG_W-1:0]  oreg;
  } issue_entry_t;

endpackage

// File: rtl/mips_issue_fifo.sv
// Synchronous FIFO holding instruction/output-select pairs for the issue queue.
module mips_issue_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; whether an entry is valid is decided by level alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: every clocked register uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers are exactly PTR_W bits, so DEPTH being a power of two gives the wrap for free.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mips_issue_queue.sv
// Buffers instruction/output-select pairs and issues them one at a time to the
// MIPS execution stage, with issue/fail statistics and a sticky hang flag.
module mips_issue_queue
  import mips_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [INSTR_W-1:0]     src_instruction,
  input  logic [OREG_W-1:0]      src_output_reg,
  output logic                   in_valid,
  output logic [INSTR_W-1:0]     instruction,
  output logic [OREG_W-1:0]      output_reg,
  input  logic                   out_valid,
  input  logic                   instruction_fail,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       issue_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   hang
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  issue_state_t      state;
  issue_state_t      state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              hang_nxt;
  logic              issue;
  logic              push;
  logic              full;
  logic              empty;
  issue_entry_t      src_entry;
  issue_entry_t      head;

  assign src_ready = !full;
  assign push      = src_valid && src_ready;
  assign busy      = !empty || (state == S_WAIT);
  assign src_entry = '{instr: src_instruction, oreg: src_output_reg};

  mips_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (src_entry),
    .pop       (issue),
    .head_data (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // NOTE: every output of this block is given a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    hang_nxt     = hang;
    issue        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          issue        = 1'b1;
          state_nxt    = S_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        // A completion always wins over a timeout landing in the same cycle.
        if (out_valid) begin
          if (!empty) begin
            issue        = 1'b1;
            wait_cnt_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          hang_nxt     = 1'b1;
          state_nxt    = S_IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      hang        <= 1'b0;
      in_valid    <= 1'b0;
      instruction <= '0;
      output_reg  <= '0;
      issue_cnt   <= '0;
      fail_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      hang     <= hang_nxt;
      in_valid <= issue;
      if (issue) begin
        instruction <= head.instr;
        output_reg  <= head.oreg;
        if (issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
      end
      // out_valid outside S_WAIT is a stray pulse and must not touch statistics.
      if ((state == S_WAIT) && out_valid && instruction_fail && (fail_cnt != '1)) begin
        fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_issue_queue.sv
// Directed bench for mips_issue_queue: scoreboarded issue data plus timing,
// back-pressure, hang, fail statistics and mid-operation reset.
module tb_mips_issue_queue;
  import mips_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               src_valid;
  logic               src_ready;
  logic [INSTR_W-1:0] src_instruction;
  logic [OREG_W-1:0]  src_output_reg;
  logic               in_valid;
  logic [INSTR_W-1:0] instruction;
  logic [OREG_W-1:0]  output_reg;
  logic               out_valid;
  logic               instruction_fail;
  logic               busy;
  logic [LVL_W-1:0]   level;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   fail_cnt;
  logic               hang;

  mips_issue_queue #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .src_instruction  (src_instruction),
    .src_output_reg   (src_output_reg),
    .in_valid         (in_valid),
    .instruction      (instruction),
    .output_reg       (output_reg),
    .out_valid        (out_valid),
    .instruction_fail (instruction_fail),
    .busy             (busy),
    .level            (level),
    .issue_cnt        (issue_cnt),
    .fail_cnt         (fail_cnt),
    .hang             (hang)
  );

  always #5 clk = ~clk;

  issue_entry_t sb_q[$];
  bit           fail_q[$];
  int checks       = 0;
  int failures     = 0;
  int cyc          = 0;
  int last_issue   = -100;
  int issue_gap    = 0;
  int issues_seen  = 0;
  int max_level    = 0;
  bit responsive   = 1'b1;
  bit spurious     = 1'b0;
  bit pending_resp = 1'b0;
  bit pending_fail = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted pushes, cross the edge, check any issue against
  // the scoreboard, then drive the stage model for the following cycle.
  task automatic step();
    if (rst_n && src_valid && src_ready) begin
      sb_q.push_back('{instr: src_instruction, oreg: src_output_reg});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (in_valid) begin
      if (sb_q.size() == 0) begin
        check("issue_unexpected", 1, 0);
      end else begin
        issue_entry_t e;
        e = sb_q.pop_front();
        check("issue_instr", instruction, e.instr);
        check("issue_oreg", output_reg, e.oreg);
      end
      issue_gap  = cyc - last_issue;
      last_issue = cyc;
      issues_seen++;
    end
    if (int'(level) > max_level) max_level = int'(level);
    out_valid        = pending_resp || spurious;
    instruction_fail = pending_resp ? pending_fail : spurious;
    pending_resp     = in_valid && responsive;
    pending_fail     = (in_valid && fail_q.size() > 0) ? fail_q.pop_front() : 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 100 && busy; g++) step();
    check(tag, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int burst_issues;
    int refused;
    int seen_before;
    bit acc;

    rst_n = 1'b0;
    src_valid = 1'b0;
    src_instruction = '0;
    src_output_reg = '0;
    out_valid = 1'b0;
    instruction_fail = 1'b0;

    // Reset values
    step();
    step();
    check("rst_src_ready", src_ready, 1);
    check("rst_in_valid", in_valid, 0);
    check("rst_instruction", instruction, 0);
    check("rst_output_reg", output_reg, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_issue_cnt", issue_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_hang", hang, 0);
    rst_n = 1'b1;
    step();

    // Single entry: accepted at N, in_valid in the cycle after N+1
    src_valid = 1'b1;
    src_instruction = 32'h2231_0005;
    src_output_reg = 20'h8_4211;
    step();
    src_valid = 1'b0;
    check("single_no_bypass", in_valid, 0);
    check("single_level", level, 1);
    step();
    check("single_in_valid", in_valid, 1);
    check("single_busy_wait", busy, 1);
    step();
    check("single_pulse_once", in_valid, 0);
    step();
    check("single_busy_done", busy, 0);
    check("single_issue_cnt", issue_cnt, 1);
    check("single_issues_seen", issues_seen, 1);

    // Continuous burst against a responsive stage, until FIFO fills and refuses
    k = 0;
    burst_issues = 0;
    refused = 0;
    max_level = 0;
    for (int g = 0; g < 200 && k < 16; g++) begin
      src_valid = 1'b1;
      src_instruction = 32'h1000_0000 + k;
      src_output_reg = 20'(k * 3 + 1);
      acc = src_ready;
      if (level == LVL_W'(DEPTH)) check("burst_full_ready", src_ready, 0);
      step();
      if (in_valid) begin
        if (burst_issues > 0) check("burst_gap", issue_gap, 2);
        burst_issues++;
      end
      if (acc) begin
        k++;
      end else begin
        // Refused while full and popping: only the pop takes effect
        refused++;
        check("full_pop_level", level, DEPTH - 1);
      end
    end
    src_valid = 1'b0;
    check("burst_all_pushed", k, 16);
    check("burst_refused", refused > 0, 1);
    check("burst_max_level", max_level, DEPTH);
    for (int g = 0; g < 100 && busy; g++) begin
      step();
      if (in_valid) begin
        if (burst_issues > 0) check("burst_gap", issue_gap, 2);
        burst_issues++;
      end
    end
    check("burst_drained", busy, 0);
    check("burst_level", level, 0);
    check("burst_issues", burst_issues, 16);
    check("burst_issue_cnt", issue_cnt, 17);
    check("burst_sb_empty", sb_q.size(), 0);

    // Hung stage: hang after TIMEOUT wait cycles, then issuing resumes
    responsive = 1'b0;
    src_valid = 1'b1;
    src_instruction = 32'hDEAD_0001;
    src_output_reg = 20'hA_BCDE;
    step();
    src_valid = 1'b0;
    step();
    check("hang_issue", in_valid, 1);
    step();
    step();
    step();
    check("hang_not_yet", hang, 0);
    step();
    check("hang_set", hang, 1);
    check("hang_idle", busy, 0);
    responsive = 1'b1;
    src_valid = 1'b1;
    src_instruction = 32'hBEEF_0002;
    src_output_reg = 20'h1_2345;
    step();
    src_valid = 1'b0;
    step();
    check("hang_resume_issue", in_valid, 1);
    drain("hang_drain");
    check("hang_sticky", hang, 1);
    check("hang_issue_cnt", issue_cnt, 19);

    // Fail statistics: three completions 1,0,1 and one stray out_valid in S_IDLE
    fail_q.push_back(1'b1);
    fail_q.push_back(1'b0);
    fail_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin
      src_valid = 1'b1;
      src_instruction = 32'h3000_0000 + i;
      src_output_reg = 20'(20'hF0000 + i);
      step();
    end
    src_valid = 1'b0;
    drain("fail_drain");
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    step();
    step();
    check("fail_cnt", fail_cnt, 2);
    check("fail_issue_cnt", issue_cnt, 22);
    check("fail_idle", busy, 0);

    // Reset with 5 entries queued and one outstanding
    responsive = 1'b0;
    for (int i = 0; i < 7; i++) begin
      src_valid = 1'b1;
      src_instruction = 32'h4000_0000 + i;
      src_output_reg = 20'(i + 7);
      step();
    end
    src_valid = 1'b0;
    check("pre_rst_level", level, 5);
    check("pre_rst_outstanding", in_valid, 1);
    rst_n = 1'b0;
    step();
    sb_q.delete();
    check("mid_rst_level", level, 0);
    check("mid_rst_in_valid", in_valid, 0);
    check("mid_rst_issue_cnt", issue_cnt, 0);
    check("mid_rst_fail_cnt", fail_cnt, 0);
    check("mid_rst_hang", hang, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_src_ready", src_ready, 1);
    rst_n = 1'b1;
    responsive = 1'b1;
    seen_before = issues_seen;
    for (int i = 0; i < 8; i++) step();
    check("post_rst_no_issue", issues_seen - seen_before, 0);
    check("post_rst_issue_cnt", issue_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
